// File: rtl/rr_queue_bank.sv
// Bank of three independent circular FIFOs feeding one registered pop port.
// A one-hot grant pops a queue; error pulses flag dropped writes and illegal grants.
module rr_queue_bank #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [2:0]    wr_en,
    input  logic [DW-1:0] wr_data0,
    input  logic [DW-1:0] wr_data1,
    input  logic [DW-1:0] wr_data2,
    output logic          q0_rdy,
    output logic          q1_rdy,
    output logic          q2_rdy,
    input  logic [2:0]    sel,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    output logic [1:0]    dout_qid,
    output logic [2:0]    full,
    output logic          ovf_err,
    output logic          sel_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DW-1:0] mem_q    [3][DEPTH];
    logic [DW-1:0] mem_d    [3][DEPTH];
    logic [AW-1:0] wr_ptr_q [3];
    logic [AW-1:0] wr_ptr_d [3];
    logic [AW-1:0] rd_ptr_q [3];
    logic [AW-1:0] rd_ptr_d [3];
    logic [CW-1:0] cnt_q    [3];
    logic [CW-1:0] cnt_d    [3];

    logic [DW-1:0] dout_q, dout_d;
    logic [1:0]    qid_q, qid_d;
    logic          vld_q, vld_d;
    logic          ovf_q, ovf_d;
    logic          serr_q, serr_d;

    logic [DW-1:0] wr_data [3];
    logic [2:0]    rdy;
    logic [2:0]    pop;
    logic [2:0]    push;
    logic          sel_onehot;

    assign wr_data[0] = wr_data0;
    assign wr_data[1] = wr_data1;
    assign wr_data[2] = wr_data2;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rdy[i]  = (cnt_q[i] != '0);
            full[i] = (cnt_q[i] == FULL_CNT);
        end
    end

    assign q0_rdy = rdy[0];
    assign q1_rdy = rdy[1];
    assign q2_rdy = rdy[2];

    // A full queue still accepts a write when it is popped in the same cycle.
    assign sel_onehot = (sel == 3'b001) || (sel == 3'b010) || (sel == 3'b100);
    assign pop        = sel_onehot ? (sel & rdy) : 3'b000;
    assign push       = wr_en & (~full | pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        qid_d    = qid_q;
        vld_d    = |pop;
        ovf_d    = |(wr_en & full & ~pop);
        serr_d   = (sel != 3'b000) && (pop == 3'b000);
        for (int i = 0; i < 3; i++) begin
            if (push[i]) begin
                mem_d[i][wr_ptr_q[i]] = wr_data[i];
                wr_ptr_d[i]           = wr_ptr_q[i] + AW'(1);
            end
            if (pop[i]) begin
                rd_ptr_d[i] = rd_ptr_q[i] + AW'(1);
                dout_d      = mem_q[i][rd_ptr_q[i]];
                qid_d       = 2'(i);
            end
            cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
                cnt_q[i]    <= '0;
            end
            dout_q <= '0;
            qid_q  <= '0;
            vld_q  <= 1'b0;
            ovf_q  <= 1'b0;
            serr_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            qid_q    <= qid_d;
            vld_q    <= vld_d;
            ovf_q    <= ovf_d;
            serr_q   <= serr_d;
        end
    end

    assign dout     = dout_q;
    assign dout_qid = qid_q;
    assign dout_vld = vld_q;
    assign ovf_err  = ovf_q;
    assign sel_err  = serr_q;

endmodule
